// File: rtl/dmem_ctrl.sv
// Load/store sequencer and round-robin two-port arbiter in front of a word-wide data memory.
// Byte and halfword accesses sit on the word memory; sub-word stores use read-modify-write.
module dmem_ctrl #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_we,
  input  logic [1:0]  a_size,
  input  logic        a_unsigned,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_done,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_we,
  input  logic [1:0]  b_size,
  input  logic        b_unsigned,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        mem_store,
  output logic        mem_load,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant, owner;  // 1 selects port B
  logic        grant_a, grant_b, accept;
  logic        cmd_we, cmd_uns, cmd_err, cmd_sub;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata, merge_word, resp_rdata;
  logic        resp_err;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic [31:0]        res;
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0: if (uns) res = {24'd0, lane_b}; else res = 32'(lane_b);
      2'd1: if (uns) res = {16'd0, lane_h}; else res = 32'(lane_h);
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] res;
    res = word;
    if (size == 2'd0) res[{off, 3'b000} +: 8] = wdata[7:0];
    else              res[{off[1], 4'b0000} +: 16] = wdata[15:0];
    return res;
  endfunction

  always_comb begin
    grant_a = a_valid && (!b_valid || last_grant);
    grant_b = b_valid && !grant_a;
    accept  = (state == IDLE) && !rst && (grant_a || grant_b);
    cmd_err = (cmd_size == 2'd3) ||
              (cmd_size == 2'd1 && cmd_addr[0]) ||
              (cmd_size == 2'd2 && cmd_addr[1:0] != 2'b00) ||
              ({1'b0, cmd_addr} >= MEM_BYTES);
    cmd_sub = cmd_we && (cmd_size != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant_b;
        last_grant <= grant_b;
      end
    end
  end

  // command, merge and response registers carry data only
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_we    <= grant_b ? b_we       : a_we;
      cmd_size  <= grant_b ? b_size     : a_size;
      cmd_uns   <= grant_b ? b_unsigned : a_unsigned;
      cmd_addr  <= grant_b ? b_addr     : a_addr;
      cmd_wdata <= grant_b ? b_wdata    : a_wdata;
    end
    if (state == ACCESS) begin
      merge_word <= mem_rdata;
      resp_err   <= cmd_err;
      if (cmd_err || cmd_we) resp_rdata <= '0;
      else resp_rdata <= load_extend(mem_rdata, cmd_addr[1:0], cmd_size, cmd_uns);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = (!cmd_err && cmd_sub) ? MERGE : RESP;
      MERGE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    a_rdata   = '0;
    b_rdata   = '0;
    a_err     = 1'b0;
    b_err     = 1'b0;
    mem_store = 1'b0;
    mem_load  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        a_ready = accept && grant_a;
        b_ready = accept && grant_b;
      end
      ACCESS: begin
        mem_addr = {cmd_addr[31:2], 2'b00};
        if (!cmd_err) begin
          if (!cmd_we || cmd_sub) mem_load = 1'b1;
          else begin
            mem_store = 1'b1;
            mem_wdata = cmd_wdata;
          end
        end
      end
      MERGE: begin
        mem_addr  = {cmd_addr[31:2], 2'b00};
        mem_store = 1'b1;
        mem_wdata = merge_lane(merge_word, cmd_wdata, cmd_addr[1:0], cmd_size);
      end
      default: begin
        if (owner) begin
          b_done  = 1'b1;
          b_rdata = resp_rdata;
          b_err   = resp_err;
        end else begin
          a_done  = 1'b1;
          a_rdata = resp_rdata;
          a_err   = resp_err;
        end
      end
    endcase
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Load/store sequencer and two-port arbiter in front of the word-wide data memory. The data memory has synchronous write, asynchronous read and word addressing via addr[31:2].
- Shares the memory between the core load/store stage (port A) and a debug/loader port (port B).
- Implements byte and halfword accesses (LB/LH/LBU/LHU/SB/SH) on top of the word memory. Sub-word stores use read-modify-write.
- Reports misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the memory. Byte address >= MEM_WORDS*4 is out of range.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- a_valid  in  1  port A request valid
- a_ready  out  1  port A request accepted this cycle
- a_we  in  1  1 = store, 0 = load
- a_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as misaligned)
- a_unsigned  in  1  zero-extend load result
- a_addr  in  32  byte address
- a_wdata  in  32  store data, right-aligned
- a_done  out  1  one-cycle completion pulse
- a_rdata  out  32  extended load data, valid with a_done
- a_err  out  1  misaligned or out-of-range, valid with a_done
- b_*  same set as a_* for port B
- mem_store  out  1  memory write strobe
- mem_load  out  1  memory read enable
- mem_addr  out  32  memory byte address, always word-aligned
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

Behaviour:
- rst: asynchronous, active-high; clk rising edge.
- Reset values:
  - State = IDLE; all outputs 0, including every ready, done, err, rdata and all mem_* signals.
  - last_grant = B, so port A wins the first tie.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - ready is combinational. It is asserted only to the winner, and only when that port's valid is high.
  - Arbitration: a single requester wins. If both request, the port not in last_grant wins (round-robin).
  - On accept: latch we, size, unsigned, addr and wdata into the command register; record owner; update last_grant; go to ACCESS.
- ACCESS (mem_addr = {addr[31:2], 2'b00}):
  - Error check: half with addr[0]=1, word with addr[1:0]≠0, size=3, or out of range. On error, no mem strobe; set err; rdata = 0; go to RESP.
  - Load: mem_load = 1. Capture mem_rdata, select the lane by addr[1:0], sign- or zero-extend, go to RESP.
  - Word store: mem_store = 1, mem_wdata = wdata; go to RESP.
  - Sub-word store: mem_load = 1; capture mem_rdata into the merge register; go to MERGE.
- MERGE:
  - mem_store = 1.
  - mem_wdata = captured word with the byte or half lane replaced by wdata[7:0] or wdata[15:0] at addr[1:0].
  - Go to RESP.
- RESP:
  - Owner's done = 1 for exactly one cycle, with rdata and err.
  - Go to IDLE. No accept occurs in RESP.
- Latency:
  - Accept to done: 2 cycles for load, word store and error.
  - Accept to done: 3 cycles for sub-word store.
  - The next accept can happen in the cycle after done.
- Only one transaction is outstanding at a time. The non-owner's ready stays 0 until IDLE; a requester holds valid and fields stable until ready.
- mem_store and mem_load are never high in IDLE or RESP, and never both high in the same cycle.
- Store rdata output = 0.
- Reset mid-transaction: state returns to IDLE at once and strobes drop asynchronously. The in-flight request gets no done. A store is committed only if its write edge occurred before reset.

Test Plan:
- Port A word store 0xDEADBEEF @0x10, then load word @0x10 -> mem_store one cycle in ACCESS; a_done 2 cycles after accept with a_rdata = 0xDEADBEEF, a_err = 0.
- SB 0x5A @0x11 over word 0xDEADBEEF -> load cycle then store cycle with mem_wdata 0xDEAD5AEF. LB @0x13 returns 0xFFFFFFDE; LBU @0x13 returns 0x000000DE.
- SH 0x8001 @0x22 -> mem_wdata upper half 0x8001. LH returns 0xFFFF8001; LHU returns 0x00008001.
- LH @0x13, LW @0x12, and LW @ MEM_WORDS*4 -> done with err = 1, rdata = 0; mem_store and mem_load stay 0 throughout.
- A and B valid every cycle for 6 requests -> grants alternate A, B, A, B, A, B starting with A; each done goes only to its owner; no overlap.
- Assert rst while in MERGE -> all outputs 0 immediately, no done; after release, a fresh port B load completes normally.
